// File: rtl/priority_scan_encoder_if.sv
// priority_scan_encoder_if -- handshake bundle for the priority scan encoder.
//   in_valid/in_ready/in_vec : vector load handshake (producer -> block)
//   abort                    : synchronous scan cancel
//   out_valid/out_ready      : index stream handshake (block -> consumer)
//   out_index/out_last/out_remaining : current winner, final flag, pending count
//   zero_pulse               : one-cycle flag, accepted vector was empty
// The block itself connects through the slave modport; master is the
// producer/consumer side.
interface priority_scan_encoder_if #(
    parameter int WIDTH = 256,
    parameter int IDXW  = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [IDXW-1:0]  out_index;
    logic             out_last;
    logic [IDXW:0]    out_remaining;
    logic             zero_pulse;

    modport slave (
        input  in_valid, in_vec, abort, out_ready,
        output in_ready, out_valid, out_index, out_last, out_remaining, zero_pulse
    );

    modport master (
        output in_valid, in_vec, abort, out_ready,
        input  in_ready, out_valid, out_index, out_last, out_remaining, zero_pulse
    );
endinterface

// File: rtl/priority_scan_encoder.sv
// priority_scan_encoder -- accepts a request vector and emits the index of
// every set bit, one per accepted output beat, in priority order (highest
// index first when MSB_FIRST=1, lowest first otherwise).
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : priority_scan_encoder_if.slave (load handshake, abort,
//           index stream, remaining count, zero_pulse)
module priority_scan_encoder #(
    parameter int WIDTH     = 256,
    parameter int IDXW      = $clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    priority_scan_encoder_if.slave  bus
);
    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state;
    logic             alive;       // 0 until the first edge after reset release
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] win_onehot;
    logic [WIDTH-1:0] pending_nxt;
    logic [IDXW-1:0]  out_index_q;
    logic             out_last_q;
    logic [IDXW:0]    remaining_q;
    logic             zero_pulse_q;

    // Winner of a vector: last hit in the scan direction wins.
    function automatic logic [IDXW-1:0] pick(input logic [WIDTH-1:0] v);
        logic [IDXW-1:0] r;
        r = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) if (v[i]) r = IDXW'(i);
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) if (v[i]) r = IDXW'(i);
        end
        return r;
    endfunction

    function automatic logic [IDXW:0] popcount(input logic [WIDTH-1:0] v);
        logic [IDXW:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) c = c + (IDXW+1)'(v[i]);
        return c;
    endfunction

    // out_index is registered and always names the current winner in SCAN,
    // so the bit to clear on a handshake is just its one-hot decode.
    always_comb begin
        win_onehot = '0;
        win_onehot[out_index_q] = 1'b1;
        pending_nxt = pending & ~win_onehot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            alive        <= 1'b0;
            pending      <= '0;
            out_index_q  <= '0;
            out_last_q   <= 1'b0;
            remaining_q  <= '0;
            zero_pulse_q <= 1'b0;
        end else begin
            alive        <= 1'b1;
            zero_pulse_q <= 1'b0;
            case (state)
                IDLE: begin
                    // abort in IDLE suppresses the load
                    if (bus.in_valid && alive && !bus.abort) begin
                        pending     <= bus.in_vec;
                        remaining_q <= popcount(bus.in_vec);
                        if (bus.in_vec == '0) begin
                            zero_pulse_q <= 1'b1;
                        end else begin
                            state       <= SCAN;
                            out_index_q <= pick(bus.in_vec);
                            out_last_q  <= (popcount(bus.in_vec) == (IDXW+1)'(1));
                        end
                    end
                end
                SCAN: begin
                    if (bus.abort) begin
                        // beat presented this cycle is dropped, not delivered
                        state       <= IDLE;
                        pending     <= '0;
                        remaining_q <= '0;
                        out_last_q  <= 1'b0;
                    end else if (bus.out_ready) begin
                        pending     <= pending_nxt;
                        remaining_q <= remaining_q - 1'b1;
                        out_index_q <= pick(pending_nxt);
                        out_last_q  <= (remaining_q == (IDXW+1)'(2));
                        if (remaining_q == (IDXW+1)'(1)) begin
                            state      <= IDLE;
                            out_last_q <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = alive && (state == IDLE);
    assign bus.out_valid     = (state == SCAN);
    assign bus.out_index     = out_index_q;
    assign bus.out_last      = out_last_q;
    assign bus.out_remaining = remaining_q;
    assign bus.zero_pulse    = zero_pulse_q;
endmodule

// File: tb/tb_priority_scan_encoder.sv
// tb_priority_scan_encoder -- two encoders (MSB_FIRST=1 and 0) share the load
// stimulus; each has its own out_ready. A set-of-pending-bits model predicts
// every output each cycle; delivered index logs are pinned by literal lists.
module tb_priority_scan_encoder;
    localparam int W  = 256;
    localparam int IW = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  in_vec;
    logic          abort;
    logic [1:0]    rdy;

    int errors = 0;
    int nchk   = 0;

    priority_scan_encoder_if #(.WIDTH(W), .IDXW(IW)) if0 ();
    priority_scan_encoder_if #(.WIDTH(W), .IDXW(IW)) if1 ();

    assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
    assign if0.in_vec   = in_vec;    assign if1.in_vec   = in_vec;
    assign if0.abort    = abort;     assign if1.abort    = abort;
    assign if0.out_ready = rdy[0];   assign if1.out_ready = rdy[1];

    priority_scan_encoder #(.WIDTH(W), .IDXW(IW), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    priority_scan_encoder #(.WIDTH(W), .IDXW(IW), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // DUT outputs gathered per instance
    logic [1:0]    dv, dr, dl, dz;
    logic [IW-1:0] di [2];
    logic [IW:0]   drem [2];
    assign dv = {if1.out_valid, if0.out_valid};
    assign dr = {if1.in_ready,  if0.in_ready};
    assign dl = {if1.out_last,  if0.out_last};
    assign dz = {if1.zero_pulse, if0.zero_pulse};
    assign di[0] = if0.out_index;     assign di[1] = if1.out_index;
    assign drem[0] = if0.out_remaining; assign drem[1] = if1.out_remaining;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- model: pending set per instance ----------------
    logic [W-1:0] mpend [2];
    logic [1:0]   mzp;
    bit           malive;
    int           log0[$];
    int           log1[$];

    // highest (msb) or lowest set index; -1 if empty
    function automatic int win(input logic [W-1:0] v, input bit msb);
        int r = -1;
        for (int i = 0; i < W; i++) if (v[i] && (msb || r < 0)) r = i;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mpend[0] = '0; mpend[1] = '0; mzp = '0; malive = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                mzp[k] = 1'b0;
                if (mpend[k] == '0) begin
                    if (in_valid && malive && !abort) begin
                        mpend[k] = in_vec;
                        mzp[k]   = (in_vec == '0);
                    end
                end else if (abort) begin
                    mpend[k] = '0;
                end else if (rdy[k]) begin
                    int w;
                    w = win(mpend[k], k == 0);
                    if (k == 0) log0.push_back(w); else log1.push_back(w);
                    mpend[k][w] = 1'b0;
                end
            end
            malive = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int cnt;
            cnt = $countones(mpend[k]);
            chk($sformatf("out_valid[%0d]", k), int'(dv[k]), int'(cnt != 0));
            chk($sformatf("in_ready[%0d]", k), int'(dr[k]), int'(malive && cnt == 0));
            chk($sformatf("zero_pulse[%0d]", k), int'(dz[k]), int'(mzp[k]));
            chk($sformatf("out_remaining[%0d]", k), int'(drem[k]), cnt);
            chk($sformatf("out_last[%0d]", k), int'(dl[k]), int'(cnt == 1));
            if (cnt != 0)
                chk($sformatf("out_index[%0d]", k), int'(di[k]), win(mpend[k], k == 0));
            if (!rst_n)
                chk($sformatf("rst_index[%0d]", k), int'(di[k]), 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] v);
        step();
        in_valid = 1'b1;
        in_vec   = v;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        rdy = 2'b11;
        abort = 1'b0;
        while (!(if0.in_ready && if1.in_ready) && n < 600) begin
            step();
            n++;
        end
        chk({name, "_idle_timeout"}, int'(n < 600), 1);
    endtask

    function automatic logic [W-1:0] gen_vec();
        logic [W-1:0] a, b;
        for (int j = 0; j < W / 32; j++) begin
            a[32*j +: 32] = $urandom;
            b[32*j +: 32] = $urandom;
        end
        case ($urandom_range(0, 5))
            0: return '0;
            1: begin a = '0; a[$urandom_range(0, W - 1)] = 1'b1; return a; end
            2: return '1;
            3: return a;
            4: return a & b & {a[W-9:0], a[W-1:W-8]};
            default: begin
                a = '0;
                for (int j = 0; j < 4; j++) a[$urandom_range(0, W - 1)] = 1'b1;
                return a;
            end
        endcase
    endfunction

    initial begin
        logic [W-1:0] v;
        int e038 [6] = '{255, 200, 10, 8, 4, 1};
        int e039 [6] = '{1, 4, 8, 10, 200, 255};
        int n;

        rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; abort = 1'b0; rdy = 2'b00;
        repeat (3) step();
        chk("reset_in_ready", int'(if0.in_ready), 0);
        chk("reset_remaining", int'(if0.out_remaining), 0);
        rst_n = 1'b1;
        step();
        chk("in_ready_after_release", int'(if0.in_ready), 1);

        // single bit 0
        rdy = 2'b11;
        v = '0; v[0] = 1'b1;
        log0.delete(); log1.delete();
        load(v);
        chk("b0_valid", int'(if0.out_valid), 1);
        chk("b0_index", int'(if0.out_index), 0);
        chk("b0_last", int'(if0.out_last), 1);
        chk("b0_remaining", int'(if0.out_remaining), 1);
        step();
        chk("b0_idle_valid", int'(if0.out_valid), 0);
        chk("b0_idle_ready", int'(if0.in_ready), 1);
        chk("b0_log_len", log0.size(), 1);

        // six-bit vector: MSB-first streaming, LSB-first with stalls
        wait_idle("six");
        v = '0; v[255] = 1; v[200] = 1; v[10] = 1; v[8] = 1; v[4] = 1; v[1] = 1;
        log0.delete(); log1.delete();
        rdy = 2'b01;
        load(v);
        chk("six_remaining", int'(if1.out_remaining), 6);
        n = 0;
        while (!(if0.in_ready && if1.in_ready) && n < 40) begin
            rdy[1] = ~rdy[1];
            step();
            n++;
        end
        chk("six_timeout", int'(n < 40), 1);
        chk("six_msb_len", log0.size(), 6);
        chk("six_lsb_len", log1.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < log0.size()) chk($sformatf("six_msb_idx%0d", i), log0[i], e038[i]);
            if (i < log1.size()) chk($sformatf("six_lsb_idx%0d", i), log1[i], e039[i]);
        end

        // empty vector
        wait_idle("zero");
        load('0);
        chk("zero_pulse", int'(if0.zero_pulse), 1);
        chk("zero_valid", int'(if0.out_valid), 0);
        chk("zero_in_ready", int'(if0.in_ready), 1);
        step();
        chk("zero_pulse_gone", int'(if0.zero_pulse), 0);

        // all ones, abort on the fourth beat
        wait_idle("ones");
        log0.delete(); log1.delete();
        load('1);
        chk("ones_remaining", int'(if0.out_remaining), 256);
        chk("ones_first", int'(if0.out_index), 255);
        repeat (3) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_valid", int'(if0.out_valid), 0);
        chk("abort_in_ready", int'(if0.in_ready), 1);
        chk("abort_remaining", int'(if0.out_remaining), 0);
        chk("abort_msb_len", log0.size(), 3);
        chk("abort_lsb_len", log1.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < log0.size()) chk($sformatf("abort_msb_idx%0d", i), log0[i], 255 - i);
            if (i < log1.size()) chk($sformatf("abort_lsb_idx%0d", i), log1[i], i);
        end

        // reset mid-scan
        wait_idle("rst");
        rdy = 2'b00;
        v = '0; v[3] = 1; v[7] = 1; v[9] = 1; v[100] = 1; v[250] = 1;
        load(v);
        chk("rst_pre_remaining", int'(if0.out_remaining), 5);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", int'(if0.out_valid), 0);
        chk("async_remaining", int'(if0.out_remaining), 0);
        chk("async_in_ready", int'(if0.in_ready), 0);
        chk("async_index", int'(if0.out_index), 0);
        step(); step();
        rst_n = 1'b1;
        rdy = 2'b11;
        step();
        chk("post_rst_in_ready", int'(if0.in_ready), 1);
        repeat (3) begin
            step();
            chk("post_rst_no_valid", int'(if0.out_valid | if1.out_valid), 0);
        end

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            in_valid = 1'($urandom_range(0, 1));
            in_vec   = gen_vec();
            rdy[0]   = ($urandom_range(0, 3) != 0);
            rdy[1]   = ($urandom_range(0, 3) != 0);
            abort    = ($urandom_range(0, 24) == 0);
            rst_n    = ($urandom_range(0, 799) != 0);
        end
        step();
        rst_n = 1'b1; in_valid = 1'b0; abort = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, nchk);
        $finish;
    end
endmodule

// File: doc/priority_scan_encoder.md
PRIORITY_SCAN_ENCODER -- requirements
Module: priority_scan_encoder

Interface
REQ-001 The module SHALL provide parameter WIDTH, default 256, giving the number of request bits (a power of two, 2..1024).
REQ-002 The module SHALL provide parameter IDXW, default $clog2(WIDTH) = 8, giving the index width.
REQ-003 The module SHALL provide parameter MSB_FIRST, default 1: 1 = highest set index emitted first, 0 = lowest set index emitted first.
REQ-004 The module SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 The module SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 The module SHALL have port in_valid  input  1  in_vec is offered.
REQ-007 The module SHALL have port in_ready  output  1  block accepts a new vector.
REQ-008 The module SHALL have port in_vec  input  WIDTH  request vector; bit i = request i.
REQ-009 The module SHALL have port abort  input  1  synchronous scan cancel.
REQ-010 The module SHALL have port out_valid  output  1  out_index is valid.
REQ-011 The module SHALL have port out_ready  input  1  consumer accepts out_index.
REQ-012 The module SHALL have port out_index  output  IDXW  encoded index of current winning bit.
REQ-013 The module SHALL have port out_last  output  1  current index is the final pending bit.
REQ-014 The module SHALL have port out_remaining  output  IDXW+1  count of pending bits, including the current one.
REQ-015 The module SHALL have port zero_pulse  output  1  one-cycle flag: accepted vector had no set bits.

Function
REQ-016 The block SHALL implement two states: IDLE and SCAN.
REQ-017 In IDLE, in_ready SHALL be 1; in SCAN, in_ready SHALL be 0.
REQ-018 In IDLE, on a rising edge with in_valid=1, the block SHALL capture in_vec into a WIDTH-bit pending register.
REQ-019 On that capture, out_remaining SHALL be loaded with the popcount of in_vec.
REQ-020 If the captured vector has no set bits, the block SHALL stay in IDLE and assert zero_pulse for exactly the next cycle; out_valid SHALL stay 0.
REQ-021 If the captured vector has at least one set bit, the block SHALL enter SCAN; out_valid SHALL be 1 in the cycle after the capture edge (latency 1).
REQ-022 In SCAN, out_valid SHALL be 1 and out_index SHALL be the winning pending bit: the highest set index when MSB_FIRST=1, the lowest when MSB_FIRST=0.
REQ-023 Only bits equal to 1 SHALL count as pending.
REQ-024 On an edge with out_valid=1 and out_ready=1, the winning bit SHALL be cleared and out_remaining SHALL decrement by 1.
REQ-025 While out_ready=0, out_index, out_last and out_remaining SHALL hold stable.
REQ-026 out_last SHALL equal (out_remaining==1) while out_valid=1, and SHALL be 0 otherwise.
REQ-027 When the handshake consumes the last bit, the block SHALL return to IDLE; out_valid SHALL be 0 the next cycle.
REQ-028 A new vector SHALL NOT be accepted in the same cycle the last bit is consumed.
REQ-029 Throughput SHALL be one index per cycle while out_ready=1; a k-bit vector with continuous out_ready occupies k SCAN cycles plus 1 IDLE cycle.
REQ-030 abort=1 at an edge in SCAN SHALL clear the pending register and out_remaining and return the block to IDLE.
REQ-031 abort SHALL take priority over a simultaneous out handshake; that index counts as not delivered.
REQ-032 abort=1 in IDLE SHALL suppress a simultaneous capture.
REQ-033 Index WIDTH-1 SHALL encode as all-ones (255 at default), with no overflow; out_remaining SHALL reach WIDTH for an all-ones vector.

Reset
REQ-034 While rst_n=0, regardless of clk, the block SHALL be in IDLE with pending=0, out_valid=0, out_index=0, out_last=0, out_remaining=0 and zero_pulse=0.
REQ-035 While rst_n=0, in_ready SHALL be 0; in_ready SHALL be 1 from the first cycle after release.
REQ-036 Reset asserted mid-SCAN SHALL discard all pending bits; no index SHALL be emitted after release until a new vector is accepted.

Verification
REQ-037 Default params, in_vec bit0 only, out_ready=1 -> one beat: index 0, out_last=1, out_remaining=1; IDLE next cycle.
REQ-038 in_vec bits {255,200,10,8,4,1}, out_ready=1 -> indices 255,200,10,8,4,1 on consecutive cycles; out_last only on 1.
REQ-039 Same vector with MSB_FIRST=0 and out_ready toggling 1/0 -> indices 1,4,8,10,200,255, each held stable through its stall cycles.
REQ-040 in_vec=0 -> zero_pulse for one cycle, no out_valid, in_ready stays 1.
REQ-041 in_vec all-ones, abort after 3 beats coincident with out_ready=1 -> exactly 3 indices delivered (255,254,253); fourth beat discarded; IDLE next cycle.
REQ-042 rst_n low for 2 cycles in mid-SCAN with 5 bits pending -> outputs zero asynchronously; no out_valid after release until a new load.
